fpu_addsub_seq: RTL and testbench

//  Multi-cycle IEEE-754 single-precision add/subtract unit; responder side of the FPU operand interface.
//  The MIPS coprocessor-1 control issues operands with a Start pulse; this block computes A+B or A-B

---
 rtl/fpu_addsub_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_fpu_addsub_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract (truncating, flush-to-zero).
// The FSM walks IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM and returns Result with a one-cycle Done.
`timescale 1ns/1ps
module fpu_addsub_seq #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        Clk,
  input  logic        nRst,
  input  logic        Start,
  input  logic        Add_nSub,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result
);

  localparam int unsigned MW = 24;
  localparam int unsigned EW = 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADDSUB = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic          sub_q, sub_d;
  logic          sx_q, sx_d;
  logic [EW-1:0] ex_q, ex_d, ey_q, ey_d;
  logic [MW-1:0] mx_q, mx_d, my_q, my_d;
  logic          eff_sub_q, eff_sub_d;
  logic          spec_q, spec_d;
  logic [31:0]   spec_val_q, spec_val_d;
  logic [MW:0]   sum_q, sum_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [31:0]   result_q, result_d;

  // Operand decode for the UNPACK step (B sign already adjusted for subtract)
  logic          sa, sb, za, zb, nan_a, nan_b, inf_a, inf_b, swap;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] ma, mb;
  logic [30:0]   ka, kb;

  assign sa    = a_q[31];
  assign sb    = b_q[31] ^ sub_q;
  assign ea    = a_q[30:23];
  assign eb    = b_q[30:23];
  assign za    = (ea == 8'h00);
  assign zb    = (eb == 8'h00);
  assign nan_a = (ea == 8'hFF) && (a_q[22:0] != 23'h0);
  assign nan_b = (eb == 8'hFF) && (b_q[22:0] != 23'h0);
  assign inf_a = (ea == 8'hFF) && (a_q[22:0] == 23'h0);
  assign inf_b = (eb == 8'hFF) && (b_q[22:0] == 23'h0);
  assign ma    = za ? 24'h0 : {1'b1, a_q[22:0]};
  assign mb    = zb ? 24'h0 : {1'b1, b_q[22:0]};
  assign ka    = za ? 31'h0 : a_q[30:0];
  assign kb    = zb ? 31'h0 : b_q[30:0];
  assign swap  = (kb > ka);

  // Special-case resolution; priority follows the order of the if-chain
  logic        spec_hit;
  logic [31:0] spec_res;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = QNAN;
    if (nan_a || nan_b) begin
      spec_res = QNAN;
    end else if (inf_a && inf_b) begin
      spec_res = (sa == sb) ? {sa, 8'hFF, 23'h0} : QNAN;
    end else if (inf_a) begin
      spec_res = {sa, 8'hFF, 23'h0};
    end else if (inf_b) begin
      spec_res = {sb, 8'hFF, 23'h0};
    end else if (za && zb) begin
      spec_res = {sa & sb, 31'h0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic [EW-1:0] dshift;
  logic [MW-1:0] my_al;

  assign dshift = ex_q - ey_q;
  assign my_al  = (dshift >= 8'd25) ? 24'h0 : (my_q >> dshift);

  // Leading-zero count of the 24-bit magnitude for the normalising left shift
  logic [4:0] lzc;
  logic       found;

  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && sum_q[i]) begin
        lzc   = 5'(23 - i);
        found = 1'b1;
      end
    end
  end

  logic signed [9:0] exp_n;
  logic [22:0]       frac_n;
  logic [31:0]       norm_res;

  always_comb begin
    if (sum_q[24]) begin
      exp_n  = signed'({2'b00, ex_q} + 10'd1);
      frac_n = sum_q[23:1];
    end else begin
      exp_n  = signed'({2'b00, ex_q} - {5'b00000, lzc});
      frac_n = sum_q[22:0] << lzc;
    end
    if (sum_q == 25'h0) begin
      norm_res = 32'h0;
    end else if (exp_n >= 10'sd255) begin
      norm_res = {sx_q, 8'hFF, 23'h0};
    end else if (exp_n <= 10'sd0) begin
      norm_res = {sx_q, 31'h0};
    end else begin
      norm_res = {sx_q, exp_n[7:0], frac_n};
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sub_d      = sub_q;
    sx_d       = sx_q;
    ex_d       = ex_q;
    ey_d       = ey_q;
    mx_d       = mx_q;
    my_d       = my_q;
    eff_sub_d  = eff_sub_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    sum_d      = sum_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          sub_d   = Add_nSub;
          busy_d  = 1'b1;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sx_d       = swap ? sb : sa;
        ex_d       = swap ? eb : ea;
        mx_d       = swap ? mb : ma;
        ey_d       = swap ? ea : eb;
        my_d       = swap ? ma : mb;
        eff_sub_d  = sa ^ sb;
        spec_d     = spec_hit;
        spec_val_d = spec_res;
        state_d    = S_ALIGN;
      end
      S_ALIGN: begin
        my_d    = my_al;
        state_d = S_ADDSUB;
      end
      S_ADDSUB: begin
        sum_d   = eff_sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        result_d = spec_q ? spec_val_q : norm_res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      sub_q      <= 1'b0;
      sx_q       <= 1'b0;
      ex_q       <= '0;
      ey_q       <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      eff_sub_q  <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'h0;
      sum_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sub_q      <= sub_d;
      sx_q       <= sx_d;
      ex_q       <= ex_d;
      ey_q       <= ey_d;
      mx_q       <= mx_d;
      my_q       <= my_d;
      eff_sub_q  <= eff_sub_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      sum_q      <= sum_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Bench for fpu_addsub_seq: value-level reference model plus a per-cycle output checker.
`timescale 1ns/1ps
module tb_fpu_addsub_seq;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int unsigned NVEC = 11;

  logic        Clk = 1'b0;
  logic        nRst = 1'b0;
  logic        Start = 1'b0;
  logic        Add_nSub = 1'b0;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic        Busy, Done;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  fpu_addsub_seq #(.QNAN(QNAN)) dut (
    .Clk(Clk), .nRst(nRst), .Start(Start), .Add_nSub(Add_nSub),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value-level model: flush denormals, align by exponent difference with truncation, renormalise.
  function automatic logic [31:0] ref_fp(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic   sa, sb, sx, sy;
    int     ea, eb, ex, ey, d, e;
    longint ma, mb, mx, my, m, ka, kb;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return QNAN;
    if (ea == 255 && eb == 255) return (sa == sb) ? {sa, 8'hFF, 23'h0} : QNAN;
    if (ea == 255) return {sa, 8'hFF, 23'h0};
    if (eb == 255) return {sb, 8'hFF, 23'h0};
    if (ea == 0 && eb == 0) return {sa & sb, 31'h0};
    ma = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(a[22:0]);
    mb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(b[22:0]);
    ka = (ea == 0) ? 0 : longint'(a[30:0]);
    kb = (eb == 0) ? 0 : longint'(b[30:0]);
    if (kb > ka) begin
      sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
    end else begin
      sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
    end
    d  = ex - ey;
    my = (d >= 25) ? 0 : (my >> d);
    m  = (sx == sy) ? mx + my : mx - my;
    if (m == 0) return 32'h0;
    e = ex;
    while (m >= (longint'(1) << 24)) begin m = m >> 1; e++; end
    while (m < (longint'(1) << 23)) begin m = m << 1; e--; end
    if (e >= 255) return {sx, 8'hFF, 23'h0};
    if (e <= 0) return {sx, 31'h0};
    return {sx, 8'(e), 23'(m)};
  endfunction

  function automatic logic [31:0] rand_fp();
    int unsigned k = $urandom_range(0, 11);
    logic [31:0] r = $urandom;
    case (k)
      0, 1, 2, 3, 4, 5: r[30:23] = 8'($urandom_range(120, 135));
      6: r[30:0] = 31'h0;
      7: r[30:0] = {8'hFF, 23'h0};
      8: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
      9: r[30:23] = 8'h00;
      11: r[30:23] = 8'($urandom_range(250, 254));
      default: ;
    endcase
    return r;
  endfunction

  // Operation-level model: an accepted Start yields Done five clocks later carrying the reference value
  int          phase = 0;
  logic [31:0] pend = 32'h0;
  logic [31:0] exp_res = 32'h0;

  always @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      phase   = 0;
      exp_res = 32'h0;
    end else begin
      case (phase)
        0, 5: begin
          if (Start) begin
            pend  = ref_fp(A, B, Add_nSub);
            phase = 1;
          end else begin
            phase = 0;
          end
        end
        4: begin
          phase   = 5;
          exp_res = pend;
        end
        default: phase = phase + 1;
      endcase
    end
  end

  always @(negedge Clk) begin
    chk("busy", 32'(Busy), 32'(phase >= 1 && phase <= 4));
    chk("done", 32'(Done), 32'(phase == 5));
    chk("result", Result, exp_res);
    if (Busy && Done) chk("busy_and_done", 32'(1), 32'(0));
  end

  logic [31:0] va [NVEC] = '{32'h3FC00000, 32'h3FC00000, 32'h420F0000, 32'hC3A40000, 32'h42300000,
                             32'h420F0000, 32'h41A40000, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001,
                             32'h00000001};
  logic [31:0] vb [NVEC] = '{32'hC0500000, 32'h40500000, 32'h41A40000, 32'h42300000, 32'hC3A40000,
                             32'h31A40000, 32'h41A40000, 32'h7F7FFFFF, 32'h7F800000, 32'h3F800000,
                             32'h3F800000};
  logic        vs [NVEC] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] vr [NVEC] = '{32'hBFE00000, 32'hBFE00000, 32'h42610000, 32'hC38E0000, 32'hC38E0000,
                             32'h420F0000, 32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                             32'h3F800000};

  // Issue one operation at the current falling edge and check the literal result at Done
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [31:0] exp);
    Start = 1'b1; A = a; B = b; Add_nSub = sub;
    @(negedge Clk);
    Start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (Done) break;
      @(negedge Clk);
    end
    if (!Done) chk("done_timeout", 32'(Done), 32'(1));
    else chk("directed_result", Result, exp);
  endtask

  initial begin
    int cnt;

    for (int i = 0; i < int'(NVEC); i++) chk("model_pin", ref_fp(va[i], vb[i], vs[i]), vr[i]);
    chk("model_neg_zero", ref_fp(32'h80000000, 32'h80000000, 1'b0), 32'h80000000);

    repeat (2) @(negedge Clk);
    chk("reset_busy", 32'(Busy), 32'(0));
    chk("reset_result", Result, 32'h0);
    nRst = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < int'(NVEC); i++) run_op(va[i], vb[i], vs[i], vr[i]);
    run_op(32'h80000000, 32'h80000000, 1'b0, 32'h80000000);
    run_op(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000);

    // Abort an operation after UNPACK; outputs clear at once and no Done follows
    Start = 1'b1; A = 32'h3FC00000; B = 32'h3FC00000; Add_nSub = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
    #2 nRst = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'(0));
    chk("abort_done", 32'(Done), 32'(0));
    chk("abort_result", Result, 32'h0);
    @(negedge Clk);
    nRst = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge Clk);
      if (Done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'(0));

    // Start held for 12 cycles: accepted at the first and each Done cycle
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 12) begin
        Start = 1'b1; A = rand_fp(); B = rand_fp(); Add_nSub = 1'($urandom);
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
      if (Done) cnt++;
    end
    chk("held_start_dones", 32'(cnt), 32'(3));

    // Random traffic with occasional near-cancellation operands
    for (int i = 0; i < 3000; i++) begin
      Start    = ($urandom_range(0, 2) == 0);
      A        = rand_fp();
      B        = ($urandom_range(0, 3) == 0) ? (A ^ 32'($urandom_range(0, 15)) ^ {1'($urandom), 31'h0})
                                             : rand_fp();
      Add_nSub = 1'($urandom);
      @(negedge Clk);
    end
    Start = 1'b0;
    repeat (8) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
